// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame width and the
// default clock / bit-rate constants used by both the transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_CLK_FREQ  = 50000000;
    localparam int unsigned UART_BAUD      = 115200;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO buffering bytes for the UART transmitter.
// Read data is the head entry, combinationally visible; pointers wrap modulo DEPTH.
module tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing, with a byte FIFO in front of the shifter.
// The FSM pops the next byte at the end of STOP so back-to-back frames have no gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
    parameter int unsigned BAUD       = UART_BAUD,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned BW           = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two, at least 2");
    end

    tx_state_t                  state_q, state_d;
    logic [BW-1:0]              baud_q, baud_d;
    logic [2:0]                 bit_q, bit_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic                       pop;
    logic                       push;
    logic                       bit_end;
    logic [7:0]                 head_data;
    logic                       fifo_full;
    logic                       fifo_empty;

    assign ready = rst && !fifo_full;
    assign push  = valid && ready;
    assign tx    = tx_q;
    assign busy  = (state_q != IDLE) || (count != '0);

    tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data),
        .pop       (pop),
        .pop_data  (head_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State, baud counter, bit index, shifter and registered line output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic: start bit is registered on the same edge as the pop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head_data;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head_data;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLK_FREQ=1000, BAUD=100 -> 10 clocks per bit).
// Accepted bytes go to a scoreboard queue; a line monitor decodes frames and compares.
module tb_uart_tx;

    localparam int unsigned DEPTH = 8;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [3:0] count;

    int         checks;
    int         passes;
    int         cyc;
    int         rst_cnt;
    int         frames;
    logic [7:0] exp_q[$];

    uart_tx #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) rst_cnt <= rst_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Line monitor: decode each frame mid-bit; frames touched by reset are dropped.
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] e;
        logic       start_ok;
        logic       stop_ok;
        int         r0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                r0 = rst_cnt;
                repeat (4) @(negedge clk);
                start_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    got[i] = tx;
                end
                repeat (10) @(negedge clk);
                stop_ok = (tx === 1'b1);
                if (rst_cnt == r0) begin
                    checks++;
                    frames++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL frame_unexpected: got 0x%02h, no byte expected", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e || !start_ok || !stop_ok)
                            $display("FAIL frame_data: got 0x%02h start_ok=%0b stop_ok=%0b, expected 0x%02h",
                                     got, start_ok, stop_ok, e);
                        else
                            passes++;
                    end
                end
            end
        end
    end

    // Offer one byte (called at a negedge); returns the cycle index of the accepting edge.
    task automatic send(input logic [7:0] b, output int acc_cyc);
        int n;
        n = 0;
        data  = b;
        valid = 1'b1;
        while (ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            $display("FAIL send_timeout: byte 0x%02h never accepted, ready=%b", b, ready);
        end else begin
            exp_q.push_back(b);
        end
        @(negedge clk);
        acc_cyc = cyc;
        valid   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL %s_drain: pending=%0d busy=%b, expected 0 and 0", name, exp_q.size(), busy);
        else
            passes++;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        valid = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || ready !== 1'b0 || busy !== 1'b0 || count !== 4'd0)
            $display("FAIL reset_state: tx=%b ready=%b busy=%b count=%0d, expected 1 0 0 0",
                     tx, ready, busy, count);
        else
            passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || tx !== 1'b1)
            $display("FAIL reset_release: ready=%b tx=%b, expected 1 1", ready, tx);
        else
            passes++;
    endtask

    task automatic test_single();
        int k;
        int bad;
        logic [7:0] b;
        logic e;
        b   = 8'h55;
        bad = 0;
        send(b, k);
        for (int c = 1; c <= 101; c++) begin
            @(negedge clk);
            if (c <= 10)      e = 1'b0;
            else if (c <= 90) e = b[(c - 11) / 10];
            else              e = 1'b1;
            if (tx !== e) bad++;
            if (c == 100) begin
                checks++;
                if (busy !== 1'b1) $display("FAIL single_busy_hold: busy=%b at +100, expected 1", busy);
                else passes++;
            end
        end
        checks++;
        if (bad != 0) $display("FAIL single_wave: %0d bit-cycles wrong, expected 0", bad);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL single_busy_fall: busy=%b at +101, expected 0", busy);
        else passes++;
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        int k;
        int k2;
        int n;
        send(8'h44, k);
        send(8'h4C, k2);
        while (cyc < k + 100) @(negedge clk);
        checks++;
        if (tx !== 1'b1) $display("FAIL b2b_stop: tx=%b at +100, expected 1", tx);
        else passes++;
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) $display("FAIL b2b_nogap: tx=%b at +101, expected 0", tx);
        else passes++;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc - k != 201) $display("FAIL b2b_duration: busy fell at +%0d, expected +201", cyc - k);
        else passes++;
        wait_drain("b2b");
    endtask

    task automatic test_overflow();
        int k;
        int f0;
        f0 = frames;
        for (int i = 0; i < 9; i++) send(8'hA0 + 8'(i * 3), k);
        data  = 8'hEE;
        valid = 1'b1;
        checks++;
        if (count !== 4'd8 || ready !== 1'b0)
            $display("FAIL overflow_full: count=%0d ready=%b, expected 8 0", count, ready);
        else
            passes++;
        send(8'hEE, k);
        wait_drain("overflow");
        checks++;
        if (frames - f0 != 10) $display("FAIL overflow_frames: %0d frames, expected 10", frames - f0);
        else passes++;
    endtask

    task automatic test_simul();
        int k;
        int kx;
        send(8'h11, k);
        send(8'h22, kx);
        send(8'h33, kx);
        send(8'h44, kx);
        while (cyc < k + 100) @(negedge clk);
        checks++;
        if (count !== 4'd3) $display("FAIL simul_pre: count=%0d, expected 3", count);
        else passes++;
        send(8'h99, kx);
        checks++;
        if (kx != k + 101 || count !== 4'd3 || tx !== 1'b0)
            $display("FAIL simul_pushpop: edge=+%0d count=%0d tx=%b, expected +101 3 0", kx - k, count, tx);
        else
            passes++;
        wait_drain("simul");
    endtask

    task automatic test_reset_mid();
        int k;
        int kx;
        int bad;
        send(8'h52, k);
        send(8'h81, kx);
        send(8'h7E, kx);
        while (cyc < k + 45) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || count !== 4'd2)
            $display("FAIL midrst_pre: tx=%b count=%0d, expected 0 2", tx, count);
        else
            passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || count !== 4'd0 || busy !== 1'b0 || ready !== 1'b0)
            $display("FAIL midrst_abort: tx=%b count=%0d busy=%b ready=%b, expected 1 0 0 0",
                     tx, count, busy, ready);
        else
            passes++;
        rst = 1'b1;
        exp_q.delete();
        bad = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL midrst_idle: %0d cycles not idle, expected 0", bad);
        else passes++;
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        cyc     = 0;
        rst_cnt = 0;
        frames  = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_simul();
        test_reset_mid();
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_left: %0d bytes pending, expected 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
